// File: rtl/lcd_read_ctrl.sv
// HD44780 read-side bus master: timed RW=1 cycles fetching BF/AC (RS=0) or a data byte (RS=1),
// with optional busy-poll repetition. Bus ownership is negotiated through an external req/grant arbiter.
module lcd_read_ctrl #(
   parameter int SETUP_CYC   = 10,
   parameter int EN_HIGH_CYC = 25,
   parameter int HOLD_CYC    = 15,
   parameter int MAX_POLLS   = 200,
   parameter int CNT_W       = 8
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iStart,
   input  logic       iRS,
   input  logic       iPoll,
   output logic       oBus_req,
   input  logic       iBus_gnt,
   input  logic [7:0] LCD_DATA_IN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic [7:0] oData,
   output logic       oDone,
   output logic       oTimeout,
   output logic       oAbort,
   output logic       oBusy,
   output logic [2:0] oDbg_state
);

   localparam int PW = $clog2(MAX_POLLS + 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [PW-1:0]    POLL_LIMIT = PW'(MAX_POLLS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_SETUP = 3'd2,
      S_EN_HI = 3'd3,
      S_HOLD  = 3'd4,
      S_CHECK = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]   r_poll_cnt;
   logic            r_rs;
   logic            r_poll;

   logic            w_owned;
   logic            w_gnt_lost;
   logic [PW-1:0]   w_poll_next;

   // Phases in which the LCD pins are driven by this block and need the grant.
   assign w_owned     = (r_state == S_SETUP) || (r_state == S_EN_HI) ||
                        (r_state == S_HOLD)  || (r_state == S_CHECK);
   assign w_gnt_lost  = w_owned && !iBus_gnt;
   assign w_poll_next = r_poll_cnt + PW'(1);
   assign oDbg_state  = r_state;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_poll_cnt <= '0;
         r_rs       <= 1'b0;
         r_poll     <= 1'b0;
         oBus_req   <= 1'b0;
         LCD_RS     <= 1'b0;
         LCD_RW     <= 1'b0;
         LCD_EN     <= 1'b0;
         oData      <= 8'h00;
         oDone      <= 1'b0;
         oTimeout   <= 1'b0;
         oAbort     <= 1'b0;
         oBusy      <= 1'b0;
      end else begin
         oDone  <= 1'b0;
         oAbort <= 1'b0;
         if (w_gnt_lost) begin
            // Losing the bus mid-cycle: release everything at once, keep the old data byte.
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            LCD_EN   <= 1'b0;
            LCD_RW   <= 1'b0;
            LCD_RS   <= 1'b0;
            oBus_req <= 1'b0;
            oBusy    <= 1'b0;
            oTimeout <= 1'b0;
            oAbort   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  oTimeout <= 1'b0;
                  if (iStart) begin
                     r_rs       <= iPoll ? 1'b0 : iRS;
                     r_poll     <= iPoll;
                     r_poll_cnt <= '0;
                     oBus_req   <= 1'b1;
                     oBusy      <= 1'b1;
                     r_state    <= S_REQ;
                  end
               end
               S_REQ: begin
                  if (iBus_gnt) begin
                     r_cnt   <= '0;
                     LCD_RW  <= 1'b1;
                     LCD_RS  <= r_rs;
                     r_state <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  if (r_cnt == SETUP_LAST) begin
                     r_cnt   <= '0;
                     LCD_EN  <= 1'b1;
                     r_state <= S_EN_HI;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_EN_HI: begin
                  if (r_cnt == EN_LAST) begin
                     oData   <= LCD_DATA_IN;
                     r_cnt   <= '0;
                     LCD_EN  <= 1'b0;
                     r_state <= S_HOLD;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_HOLD: begin
                  if (r_cnt == HOLD_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_CHECK;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_CHECK: begin
                  if (!r_poll || !oData[7] || (w_poll_next == POLL_LIMIT)) begin
                     // Timeout only when the limit is hit while the LCD still reports busy.
                     oTimeout <= r_poll && oData[7];
                     oDone    <= 1'b1;
                     oBus_req <= 1'b0;
                     LCD_RW   <= 1'b0;
                     LCD_RS   <= 1'b0;
                     r_state  <= S_DONE;
                  end else begin
                     r_state <= S_SETUP;
                  end
                  if (r_poll) begin
                     r_poll_cnt <= w_poll_next;
                  end
               end
               S_DONE: begin
                  oTimeout <= 1'b0;
                  oBusy    <= 1'b0;
                  r_state  <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
